// File: rtl/mem_walk_seq.sv
// Walking-bit memory test sequencer: one write pass, then one read/compare pass,
// reporting pass/fail and the first failing address with its expected/got data.
module mem_walk_seq #(
    parameter int p_WIDTH      = 8,
    parameter int p_ADDR_WIDTH = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_N,
    input  logic                    i_START,
    input  logic                    i_MODE,
    output logic [p_WIDTH-1:0]      o_DIN0,
    output logic [p_WIDTH-1:0]      o_DIN1,
    output logic                    o_SEL,
    output logic [p_ADDR_WIDTH-1:0] o_ADDR,
    output logic                    o_WE,
    output logic                    o_RE,
    input  logic [p_WIDTH-1:0]      i_RDATA,
    output logic                    o_BUSY,
    output logic                    o_DONE,
    output logic                    o_PASS,
    output logic [p_ADDR_WIDTH:0]   o_ERR_CNT,
    output logic [p_ADDR_WIDTH-1:0] o_ERR_ADDR,
    output logic [p_WIDTH-1:0]      o_ERR_EXP,
    output logic [p_WIDTH-1:0]      o_ERR_GOT,
    output logic [2:0]              o_STATE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [p_ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [p_WIDTH-1:0]      PAT_INIT  = p_WIDTH'(1);

    state_t                    state_q, state_d;
    logic                      start_go;
    logic [p_ADDR_WIDTH-1:0]   addr_q;
    logic [p_WIDTH-1:0]        pat_q;
    logic [p_WIDTH-1:0]        pat_rotl;
    logic                      sel_q;
    logic                      rd_vld_q;
    logic [p_WIDTH-1:0]        exp_data_q;
    logic [p_ADDR_WIDTH-1:0]   exp_addr_q;
    logic [p_ADDR_WIDTH:0]     err_cnt_q;
    logic [p_ADDR_WIDTH-1:0]   err_addr_q;
    logic [p_WIDTH-1:0]        err_exp_q;
    logic [p_WIDTH-1:0]        err_got_q;
    logic                      active;

    // Rotation gives P(a) = 1 << (a mod p_WIDTH) for any width/depth ratio.
    assign pat_rotl = {pat_q[p_WIDTH-2:0], pat_q[p_WIDTH-1]};

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_START) begin
                    state_d  = S_WRITE;
                    start_go = 1'b1;
                end
            end
            S_WRITE: if (addr_q == LAST_ADDR) state_d = S_READ;
            S_READ:  if (addr_q == LAST_ADDR) state_d = S_CHECK;
            S_CHECK: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            addr_q     <= '0;
            pat_q      <= '0;
            sel_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            exp_data_q <= '0;
            exp_addr_q <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else if (start_go) begin
            addr_q     <= '0;
            pat_q      <= PAT_INIT;
            sel_q      <= i_MODE;
            rd_vld_q   <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            if (state_q == S_WRITE || state_q == S_READ) begin
                addr_q <= addr_q + 1'b1;
                pat_q  <= (addr_q == LAST_ADDR) ? PAT_INIT : pat_rotl;
            end
            // Expected data travels one cycle behind the read to meet i_RDATA.
            rd_vld_q   <= (state_q == S_READ);
            exp_data_q <= sel_q ? ~pat_q : pat_q;
            exp_addr_q <= addr_q;
            if (rd_vld_q && (i_RDATA != exp_data_q)) begin
                err_cnt_q <= err_cnt_q + 1'b1;
                if (err_cnt_q == '0) begin
                    err_addr_q <= exp_addr_q;
                    err_exp_q  <= exp_data_q;
                    err_got_q  <= i_RDATA;
                end
            end
        end
    end

    assign active     = (state_q == S_WRITE) || (state_q == S_READ);
    assign o_WE       = (state_q == S_WRITE);
    assign o_RE       = (state_q == S_READ);
    assign o_ADDR     = active ? addr_q : '0;
    assign o_DIN0     = active ? pat_q : '0;
    assign o_DIN1     = active ? ~pat_q : '0;
    assign o_SEL      = sel_q;
    assign o_BUSY     = active || (state_q == S_CHECK);
    assign o_DONE     = (state_q == S_DONE);
    assign o_PASS     = (state_q == S_DONE) && (err_cnt_q == '0);
    assign o_ERR_CNT  = err_cnt_q;
    assign o_ERR_ADDR = err_addr_q;
    assign o_ERR_EXP  = err_exp_q;
    assign o_ERR_GOT  = err_got_q;
    assign o_STATE    = state_q;

endmodule

// File: tb/tb_mem_walk_seq.sv
// Directed bench for mem_walk_seq: 2x1 mux plus an ideal 1-cycle memory with an
// optional stuck-at-0 read mask; write stream is checked against a scoreboard.
module tb_mem_walk_seq;

    localparam int W        = 8;
    localparam int AW       = 4;
    localparam int D        = 16;
    localparam int DONE_LAT = 33;
    localparam int MAX_CYC  = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [W-1:0]  din0, din1, rdata, wdata, fault_mask;
    logic          sel, we, re, busy, done, pass;
    logic [AW-1:0] addr, err_addr;
    logic [AW:0]   err_cnt;
    logic [W-1:0]  err_exp, err_got;
    logic [2:0]    state;

    logic [W-1:0]      mem [D];
    logic [AW+W-1:0]   exp_q[$];
    logic [AW+W-1:0]   sb_e;
    logic              cur_mode = 1'b0;
    int                sel_bad = 0;
    int                overlap = 0;
    int                vectors = 0;
    int                miscompares = 0;
    int                cyc;

    mem_walk_seq #(.p_WIDTH(W), .p_ADDR_WIDTH(AW)) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_START(start), .i_MODE(mode),
        .o_DIN0(din0), .o_DIN1(din1), .o_SEL(sel), .o_ADDR(addr),
        .o_WE(we), .o_RE(re), .i_RDATA(rdata), .o_BUSY(busy),
        .o_DONE(done), .o_PASS(pass), .o_ERR_CNT(err_cnt),
        .o_ERR_ADDR(err_addr), .o_ERR_EXP(err_exp), .o_ERR_GOT(err_got),
        .o_STATE(state)
    );

    always #5 clk = ~clk;

    // Downstream mux and memory under test.
    assign wdata = sel ? din1 : din0;
    initial rdata = '0;
    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr] & ~fault_mask;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_writes(input logic m);
        logic [W-1:0] p;
        exp_q.delete();
        for (int a = 0; a < D; a++) begin
            p = W'(1) << (a % W);
            if (m) p = ~p;
            exp_q.push_back({AW'(a), p});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (we && re) overlap++;
            if (busy && sel !== cur_mode) sel_bad++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    check_val("wr_extra", 32'd1, 32'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check_val("wr_addr", 32'(addr), 32'(sb_e[AW+W-1:W]));
                    check_val("wr_data", 32'(wdata), 32'(sb_e[W-1:0]));
                end
            end
        end
    end

    task automatic start_run(input logic m);
        mode = m;
        cur_mode = m;
        sel_bad = 0;
        load_writes(m);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~m;
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_done", 32'(done), 32'd0);
    endtask

    task automatic wait_done(input bit glitch, output int n);
        n = 0;
        while (!done && n < MAX_CYC) begin
            if (glitch && (n == 4 || n == 19)) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
    endtask

    task automatic check_end(input string tag, input logic exp_pass, input int exp_cnt);
        check_val({tag, "_lat"}, 32'(cyc), 32'(DONE_LAT));
        check_val({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check_val({tag, "_cnt"}, 32'(err_cnt), 32'(exp_cnt));
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_sel"}, 32'(sel_bad), 32'd0);
    endtask

    initial begin
        fault_mask = '0;
        #12;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_pass", 32'(pass), 32'd0);
        check_val("rst_we_re", 32'({we, re}), 32'd0);
        check_val("rst_addr", 32'(addr), 32'd0);
        check_val("rst_din", 32'({din0, din1}), 32'd0);
        check_val("rst_sel", 32'(sel), 32'd0);
        check_val("rst_errcnt", 32'(err_cnt), 32'd0);
        check_val("rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Walking ones, fault-free.
        start_run(1'b0);
        wait_done(1'b0, cyc);
        check_end("m0", 1'b1, 0);
        check_val("m0_state", 32'(state), 32'd4);
        check_val("m0_mem0", 32'(mem[0]), 32'h01);
        check_val("m0_mem7", 32'(mem[7]), 32'h80);
        check_val("m0_mem8", 32'(mem[8]), 32'h01);
        check_val("m0_mem15", 32'(mem[15]), 32'h80);

        // Walking zeros via the complement leg of the mux.
        start_run(1'b1);
        wait_done(1'b0, cyc);
        check_end("m1", 1'b1, 0);
        check_val("m1_mem3", 32'(mem[3]), 32'hF7);
        check_val("m1_sel_done", 32'(sel), 32'd1);

        // Data bit 2 stuck-at-0 on reads.
        fault_mask = 8'h04;
        start_run(1'b0);
        wait_done(1'b0, cyc);
        check_end("sa0", 1'b0, 2);
        check_val("sa0_addr", 32'(err_addr), 32'd2);
        check_val("sa0_exp", 32'(err_exp), 32'h04);
        check_val("sa0_got", 32'(err_got), 32'h00);

        // Restart from a failing DONE with the fault removed.
        fault_mask = '0;
        start_run(1'b0);
        check_val("rs_cnt_clr", 32'(err_cnt), 32'd0);
        check_val("rs_err_clr", 32'({err_addr, err_exp, err_got}), 32'd0);
        wait_done(1'b0, cyc);
        check_end("rs", 1'b1, 0);

        // Start pulses mid-run are ignored; results as for the faulty run.
        fault_mask = 8'h04;
        start_run(1'b0);
        wait_done(1'b1, cyc);
        check_end("gl", 1'b0, 2);
        check_val("gl_addr", 32'(err_addr), 32'd2);

        // Asynchronous reset during READ, then a fresh run.
        fault_mask = '0;
        start_run(1'b1);
        repeat (24) begin
            @(posedge clk);
            #1;
        end
        check_val("ar_pre_re", 32'(re), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("ar_busy", 32'(busy), 32'd0);
        check_val("ar_re", 32'(re), 32'd0);
        check_val("ar_addr", 32'(addr), 32'd0);
        check_val("ar_sel", 32'(sel), 32'd0);
        check_val("ar_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(1'b0);
        wait_done(1'b0, cyc);
        check_end("ar_run", 1'b1, 0);

        check_val("we_re_overlap", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
